// File: rtl/cpu_pkg.sv
// cpu_pkg: opcode/funct encodings, ALU operation enum and size defaults
// shared by the single-cycle MIPS-subset core.
package cpu_pkg;

    localparam int IMEM_WORDS_DEF = 1024;
    localparam int PC_W_DEF       = 10;

    // Primary opcodes
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;

    // R-type funct codes
    localparam logic [5:0] FN_SLL   = 6'b000000;
    localparam logic [5:0] FN_SRL   = 6'b000010;
    localparam logic [5:0] FN_SRA   = 6'b000011;
    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_XOR   = 6'b100110;
    localparam logic [5:0] FN_NOR   = 6'b100111;
    localparam logic [5:0] FN_SLT   = 6'b101010;
    localparam logic [5:0] FN_SLTU  = 6'b101011;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
        ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA,
        ALU_LUI, ALU_HI, ALU_LO
    } alu_op_e;

endpackage

// File: rtl/cpu_regfile.sv
// cpu_regfile: 32x32 GPR file, two async read ports, one sync write port.
// Entry 0 is never written and reads as zero. With CPU_DEBUG_PORT_EN a third
// async read port feeds the debug interface.
module cpu_regfile (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  i_ra1,
    output logic [31:0] o_rd1,
    input  logic [4:0]  i_ra2,
    output logic [31:0] o_rd2,
    input  logic        i_we,
    input  logic [4:0]  i_wa,
    input  logic [31:0] i_wd
`ifdef CPU_DEBUG_PORT_EN
    ,
    input  logic [4:0]  i_ra3,
    output logic [31:0] o_rd3
`endif
);

    logic [31:0] regs [32];

    // Synchronous clear on reset, otherwise single write; $0 is discarded.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 32; k++) regs[k] <= '0;
        end else if (i_we && (i_wa != 5'd0)) begin
            regs[i_wa] <= i_wd;
        end
    end

    assign o_rd1 = (i_ra1 == 5'd0) ? 32'd0 : regs[i_ra1];
    assign o_rd2 = (i_ra2 == 5'd0) ? 32'd0 : regs[i_ra2];
`ifdef CPU_DEBUG_PORT_EN
    assign o_rd3 = (i_ra3 == 5'd0) ? 32'd0 : regs[i_ra3];
`endif

endmodule

// File: rtl/cpu.sv
// cpu: single-cycle MIPS-subset core. Fetch, decode, ALU, HI/LO and PC logic
// are inline; the register file is a sub-module. Optional macro
// CPU_DEBUG_PORT_EN adds dbg_addr/dbg_rdata/dbg_pc observation ports.
module cpu
    import cpu_pkg::*;
#(
    parameter int IMEM_WORDS = IMEM_WORDS_DEF,
    parameter int PC_W       = PC_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [32*IMEM_WORDS-1:0] instruction_stream
`ifdef CPU_DEBUG_PORT_EN
    ,
    input  logic [4:0]              dbg_addr,
    output logic [31:0]             dbg_rdata,
    output logic [PC_W-1:0]         dbg_pc
`endif
);

    logic [PC_W-1:0] pc;
    logic [31:0]     hi, lo;

    logic [31:0]     w_instr;
    logic [5:0]      w_op, w_funct;
    logic [4:0]      w_rs, w_rt, w_rd, w_shamt;
    logic [15:0]     w_imm;
    logic [31:0]     w_simm, w_zimm;
    logic [31:0]     w_rs_val, w_rt_val, w_b, w_res;
    logic [PC_W-1:0] w_pc_inc, w_pc_br, w_pc_next;
    logic            w_we, w_mul_we, w_mul_sgn;
    logic [4:0]      w_wa;
    alu_op_e         w_alu_op;
    logic [63:0]     w_prod;

    // PC is a word index, so the bit offset is simply {pc, 5'b0}.
    assign w_instr  = instruction_stream[{pc, 5'b0} +: 32];
    assign w_op     = w_instr[31:26];
    assign w_rs     = w_instr[25:21];
    assign w_rt     = w_instr[20:16];
    assign w_rd     = w_instr[15:11];
    assign w_shamt  = w_instr[10:6];
    assign w_funct  = w_instr[5:0];
    assign w_imm    = w_instr[15:0];
    assign w_simm   = {{16{w_imm[15]}}, w_imm};
    assign w_zimm   = {16'd0, w_imm};
    assign w_pc_inc = pc + PC_W'(1);
    assign w_pc_br  = w_pc_inc + w_simm[PC_W-1:0];

    cpu_regfile rf (
        .clk   (clk),
        .rst   (rst),
        .i_ra1 (w_rs),
        .o_rd1 (w_rs_val),
        .i_ra2 (w_rt),
        .o_rd2 (w_rt_val),
        .i_we  (w_we),
        .i_wa  (w_wa),
        .i_wd  (w_res)
`ifdef CPU_DEBUG_PORT_EN
        ,
        .i_ra3 (dbg_addr),
        .o_rd3 (dbg_rdata)
`endif
    );

`ifdef CPU_DEBUG_PORT_EN
    assign dbg_pc = pc;
`endif

    // Decode: pick ALU op, second operand, write target and next PC.
    always_comb begin
        w_alu_op  = ALU_ADD;
        w_b       = w_rt_val;
        w_we      = 1'b0;
        w_wa      = w_rd;
        w_mul_we  = 1'b0;
        w_mul_sgn = 1'b0;
        w_pc_next = w_pc_inc;
        case (w_op)
            OP_RTYPE: begin
                w_we = 1'b1;
                case (w_funct)
                    FN_SLL:           w_alu_op = ALU_SLL;
                    FN_SRL:           w_alu_op = ALU_SRL;
                    FN_SRA:           w_alu_op = ALU_SRA;
                    FN_ADD, FN_ADDU:  w_alu_op = ALU_ADD;
                    FN_SUB, FN_SUBU:  w_alu_op = ALU_SUB;
                    FN_AND:           w_alu_op = ALU_AND;
                    FN_OR:            w_alu_op = ALU_OR;
                    FN_XOR:           w_alu_op = ALU_XOR;
                    FN_NOR:           w_alu_op = ALU_NOR;
                    FN_SLT:           w_alu_op = ALU_SLT;
                    FN_SLTU:          w_alu_op = ALU_SLTU;
                    FN_MFHI:          w_alu_op = ALU_HI;
                    FN_MFLO:          w_alu_op = ALU_LO;
                    FN_MULT: begin
                        w_we      = 1'b0;
                        w_mul_we  = 1'b1;
                        w_mul_sgn = 1'b1;
                    end
                    FN_MULTU: begin
                        w_we     = 1'b0;
                        w_mul_we = 1'b1;
                    end
                    FN_JR: begin
                        w_we      = 1'b0;
                        w_pc_next = w_rs_val[PC_W+1:2];
                    end
                    default:          w_we = 1'b0;
                endcase
            end
            OP_ADDI, OP_ADDIU: begin
                w_we = 1'b1; w_wa = w_rt; w_b = w_simm;
            end
            OP_SLTI: begin
                w_we = 1'b1; w_wa = w_rt; w_b = w_simm; w_alu_op = ALU_SLT;
            end
            OP_SLTIU: begin
                w_we = 1'b1; w_wa = w_rt; w_b = w_simm; w_alu_op = ALU_SLTU;
            end
            OP_ANDI: begin
                w_we = 1'b1; w_wa = w_rt; w_b = w_zimm; w_alu_op = ALU_AND;
            end
            OP_ORI: begin
                w_we = 1'b1; w_wa = w_rt; w_b = w_zimm; w_alu_op = ALU_OR;
            end
            OP_XORI: begin
                w_we = 1'b1; w_wa = w_rt; w_b = w_zimm; w_alu_op = ALU_XOR;
            end
            OP_LUI: begin
                w_we = 1'b1; w_wa = w_rt; w_alu_op = ALU_LUI;
            end
            OP_BEQ: if (w_rs_val == w_rt_val) w_pc_next = w_pc_br;
            OP_BNE: if (w_rs_val != w_rt_val) w_pc_next = w_pc_br;
            OP_J:   w_pc_next = w_instr[PC_W-1:0];
            default: ;
        endcase
    end

    // ALU: result for the GPR write port.
    always_comb begin
        case (w_alu_op)
            ALU_ADD:  w_res = w_rs_val + w_b;
            ALU_SUB:  w_res = w_rs_val - w_b;
            ALU_AND:  w_res = w_rs_val & w_b;
            ALU_OR:   w_res = w_rs_val | w_b;
            ALU_XOR:  w_res = w_rs_val ^ w_b;
            ALU_NOR:  w_res = ~(w_rs_val | w_b);
            ALU_SLT:  w_res = {31'd0, ($signed(w_rs_val) < $signed(w_b))};
            ALU_SLTU: w_res = {31'd0, (w_rs_val < w_b)};
            ALU_SLL:  w_res = w_rt_val << w_shamt;
            ALU_SRL:  w_res = w_rt_val >> w_shamt;
            ALU_SRA:  w_res = $signed(w_rt_val) >>> w_shamt;
            ALU_LUI:  w_res = {w_imm, 16'd0};
            ALU_HI:   w_res = hi;
            ALU_LO:   w_res = lo;
            default:  w_res = 32'd0;
        endcase
    end

    // Both operands widened to 64 bits so the truncated product is exact.
    assign w_prod = w_mul_sgn
        ? 64'($signed({{32{w_rs_val[31]}}, w_rs_val}) * $signed({{32{w_rt_val[31]}}, w_rt_val}))
        : ({32'd0, w_rs_val} * {32'd0, w_rt_val});

    // PC and HI/LO commit; reset wins over any commit on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= '0;
            hi <= '0;
            lo <= '0;
        end else begin
            pc <= w_pc_next;
            if (w_mul_we) begin
                hi <= w_prod[63:32];
                lo <= w_prod[31:0];
            end
        end
    end

endmodule

// File: tb/tb_cpu.sv
// tb_cpu: directed table vectors, hand-written reset sequences and a random
// program run checked against an instruction-level reference interpreter.
module tb_cpu;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [32767:0] imem = '0;
`ifdef CPU_DEBUG_PORT_EN
    logic [4:0]     dbg_addr = 5'd0;
    logic [31:0]    dbg_rdata;
    logic [9:0]     dbg_pc;
`endif

    int total = 0;
    int bad   = 0;

    cpu dut (
        .clk                (clk),
        .rst                (rst),
        .instruction_stream (imem)
`ifdef CPU_DEBUG_PORT_EN
        ,
        .dbg_addr           (dbg_addr),
        .dbg_rdata          (dbg_rdata),
        .dbg_pc             (dbg_pc)
`endif
    );

    always #5 clk = ~clk;

    // ---------------- encoders ----------------
    function automatic logic [31:0] enR(int rs, int rt, int rd, int sh, int fn);
        return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
    endfunction
    function automatic logic [31:0] enI(int op, int rs, int rt, int imm);
        return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
    endfunction
    function automatic logic [31:0] enJ(int tgt);
        return {6'd2, 26'(tgt)};
    endfunction

    // ---------------- checking ----------------
    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] dut_val(int kind, int idx);
        case (kind)
            0: return dut.rf.regs[idx];
            1: return dut.hi;
            2: return dut.lo;
            default: return 32'(dut.pc);
        endcase
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // ---------------- reference interpreter ----------------
    bit [31:0] mem   [1024];
    bit [31:0] mreg  [32];
    bit [31:0] mhi, mlo;
    int        mpc;

    task automatic mreset();
        for (int k = 0; k < 32; k++) mreg[k] = 0;
        mhi = 0; mlo = 0; mpc = 0;
    endtask

    task automatic mstep();
        bit [31:0] ins, a, b, r, se;
        bit [63:0] p;
        int op, fn, rs, rt, rd, sh, simm, npc, wa;
        bit we;
        ins  = mem[mpc];
        op   = int'(ins[31:26]); fn = int'(ins[5:0]);
        rs   = int'(ins[25:21]); rt = int'(ins[20:16]);
        rd   = int'(ins[15:11]); sh = int'(ins[10:6]);
        simm = int'($signed(ins[15:0]));
        se   = 32'(simm);
        a = mreg[rs]; b = mreg[rt];
        npc = mpc + 1; we = 0; wa = rt; r = 0;
        if (op == 0) begin
            wa = rd; we = 1;
            case (fn)
                0:      r = b << sh;
                2:      r = b >> sh;
                3:      r = 32'($signed(b) >>> sh);
                32, 33: r = a + b;
                34, 35: r = a - b;
                36:     r = a & b;
                37:     r = a | b;
                38:     r = a ^ b;
                39:     r = ~(a | b);
                42:     r = ($signed(a) < $signed(b)) ? 1 : 0;
                43:     r = (a < b) ? 1 : 0;
                16:     r = mhi;
                18:     r = mlo;
                24: begin
                    we = 0;
                    p = 64'(longint'($signed(a)) * longint'($signed(b)));
                    mhi = p[63:32]; mlo = p[31:0];
                end
                25: begin
                    we = 0;
                    p = {32'd0, a} * {32'd0, b};
                    mhi = p[63:32]; mlo = p[31:0];
                end
                8: begin we = 0; npc = int'(a / 4); end
                default: we = 0;
            endcase
        end else begin
            case (op)
                8, 9: begin we = 1; r = a + se; end
                10:   begin we = 1; r = ($signed(a) < $signed(se)) ? 1 : 0; end
                11:   begin we = 1; r = (a < se) ? 1 : 0; end
                12:   begin we = 1; r = a & {16'd0, ins[15:0]}; end
                13:   begin we = 1; r = a | {16'd0, ins[15:0]}; end
                14:   begin we = 1; r = a ^ {16'd0, ins[15:0]}; end
                15:   begin we = 1; r = {ins[15:0], 16'd0}; end
                4:    if (a == b) npc = mpc + 1 + simm;
                5:    if (a != b) npc = mpc + 1 + simm;
                2:    npc = int'(ins[25:0]);
                default: ;
            endcase
        end
        if (we && wa != 0) mreg[wa] = r;
        mpc = npc & 1023;
    endtask

    function automatic logic [31:0] rnd_instr();
        int fns [18] = '{0, 2, 3, 32, 33, 34, 35, 36, 37, 38, 39, 42, 43, 24, 25, 16, 18, 8};
        int ops [11] = '{8, 9, 10, 11, 12, 13, 14, 15, 4, 5, 2};
        int k  = int'($urandom_range(0, 99));
        int rs = int'($urandom_range(0, 7));
        int rt = int'($urandom_range(0, 7));
        int rd = int'($urandom_range(0, 7));
        if (k < 55) return enR(rs, rt, rd, int'($urandom_range(0, 31)), fns[$urandom_range(0, 17)]);
        if (k < 95) return enI(ops[$urandom_range(0, 10)], rs, rt, int'($urandom));
        return 32'($urandom);
    endfunction

    // ---------------- directed table ----------------
    typedef struct {
        string       name;
        int          pid;
        int          cyc;
        int          kind;   // 0 GPR, 1 HI, 2 LO, 3 PC
        int          idx;
        logic [31:0] exp;
    } vec_t;

    logic [31:0] progs [9][8];
    vec_t        vt [$];

    task automatic addv(string nm, int pid, int cyc, int kind, int idx, logic [31:0] exp);
        vec_t v;
        v.name = nm; v.pid = pid; v.cyc = cyc; v.kind = kind; v.idx = idx; v.exp = exp;
        vt.push_back(v);
    endtask

    task automatic load_prog(int pid);
        imem = '0;
        for (int k = 0; k < 8; k++) imem[k*32 +: 32] = progs[pid][k];
    endtask

    initial begin
        int bad0;
        for (int p = 0; p < 9; p++)
            for (int k = 0; k < 8; k++) progs[p][k] = 32'd0;
        // 0: arithmetic / multiply chain
        progs[0][0] = enI(8, 0, 1, 2);       progs[0][1] = enR(1, 1, 1, 0, 32);
        progs[0][2] = enI(8, 0, 2, 7);       progs[0][3] = enR(1, 2, 0, 0, 24);
        progs[0][4] = enR(0, 0, 3, 0, 18);   progs[0][5] = enR(0, 3, 3, 3, 2);
        // 1: signed and unsigned multiply
        progs[1][0] = enI(8, 0, 1, -3);      progs[1][1] = enI(8, 0, 2, 5);
        progs[1][2] = enR(1, 2, 0, 0, 24);   progs[1][3] = enR(0, 0, 4, 0, 16);
        progs[1][4] = enR(0, 0, 5, 0, 18);   progs[1][5] = enR(1, 2, 0, 0, 25);
        // 2: $0 protection
        progs[2][0] = enI(8, 0, 0, 5);       progs[2][1] = enR(0, 0, 1, 0, 32);
        // 3-5: control flow
        progs[3][0] = enI(4, 0, 0, 2);
        progs[4][0] = enI(5, 0, 0, 5);
        progs[5][0] = enJ(1023);
        // 6: logic / compare
        progs[6][0] = enI(15, 0, 1, 16'h8000); progs[6][1] = enR(1, 0, 2, 0, 42);
        progs[6][2] = enR(1, 0, 3, 0, 43);     progs[6][3] = enR(0, 0, 4, 0, 39);
        progs[6][4] = enR(0, 1, 5, 4, 3);
        // 7: immediates and jr
        progs[7][0] = enI(11, 0, 1, -1);       progs[7][1] = enI(13, 0, 2, 16'h8001);
        progs[7][2] = enI(10, 0, 3, -1);       progs[7][3] = enI(14, 2, 4, 16'hFFFF);
        progs[7][4] = enI(8, 0, 6, 20);        progs[7][5] = enR(6, 0, 0, 0, 8);
        // 8: wrap-around add/sub
        progs[8][0] = enI(15, 0, 1, 16'h7FFF); progs[8][1] = enR(1, 1, 2, 0, 32);
        progs[8][2] = enR(0, 1, 3, 0, 34);

        addv("chain_r1", 0, 6, 0, 1, 32'd4);
        addv("chain_r2", 0, 6, 0, 2, 32'd7);
        addv("chain_hi", 0, 6, 1, 0, 32'd0);
        addv("chain_lo", 0, 6, 2, 0, 32'd28);
        addv("chain_r3_e5", 0, 5, 0, 3, 32'd28);
        addv("chain_r3_e6", 0, 6, 0, 3, 32'd3);
        addv("chain_nop_r3", 0, 9, 0, 3, 32'd3);
        addv("chain_nop_pc", 0, 9, 3, 0, 32'd9);
        addv("mult_hi_r4", 1, 6, 0, 4, 32'hFFFFFFFF);
        addv("mult_lo_r5", 1, 6, 0, 5, 32'hFFFFFFF1);
        addv("multu_hi", 1, 6, 1, 0, 32'h00000004);
        addv("multu_lo", 1, 6, 2, 0, 32'hFFFFFFF1);
        addv("zero_r0", 2, 2, 0, 0, 32'd0);
        addv("zero_r1", 2, 2, 0, 1, 32'd0);
        addv("beq_pc", 3, 1, 3, 0, 32'd3);
        addv("bne_pc", 4, 1, 3, 0, 32'd1);
        addv("j_pc", 5, 1, 3, 0, 32'd1023);
        addv("j_wrap_pc", 5, 2, 3, 0, 32'd0);
        addv("lui_r1", 6, 5, 0, 1, 32'h80000000);
        addv("slt_r2", 6, 5, 0, 2, 32'd1);
        addv("sltu_r3", 6, 5, 0, 3, 32'd0);
        addv("nor_r4", 6, 5, 0, 4, 32'hFFFFFFFF);
        addv("sra_r5", 6, 5, 0, 5, 32'hF8000000);
        addv("sltiu_r1", 7, 6, 0, 1, 32'd1);
        addv("ori_r2", 7, 6, 0, 2, 32'h00008001);
        addv("slti_r3", 7, 6, 0, 3, 32'd0);
        addv("xori_r4", 7, 6, 0, 4, 32'h00007FFE);
        addv("jr_pc", 7, 6, 3, 0, 32'd5);
        addv("add_wrap_r2", 8, 3, 0, 2, 32'hFFFE0000);
        addv("sub_wrap_r3", 8, 3, 0, 3, 32'h80010000);

        foreach (vt[i]) begin
            load_prog(vt[i].pid);
            do_reset();
            repeat (vt[i].cyc) @(posedge clk);
            #1 chk(vt[i].name, dut_val(vt[i].kind, vt[i].idx), vt[i].exp);
        end

        // Mid-program reset overrides the commit on that edge.
        load_prog(0);
        do_reset();
        repeat (3) @(posedge clk);
        #1 chk("pre_rst_r2", dut_val(0, 2), 32'd7);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_pc", dut_val(3, 0), 32'd0);
        chk("mid_rst_r1", dut_val(0, 1), 32'd0);
        chk("mid_rst_hi_lo", dut_val(1, 0) | dut_val(2, 0), 32'd0);
        rst = 1'b0;

        // Random program over the whole memory, compared every commit.
        for (int k = 0; k < 1024; k++) begin
            mem[k] = rnd_instr();
            imem[k*32 +: 32] = mem[k];
        end
        do_reset();
        mreset();
        for (int c = 0; c < 600; c++) begin
            bad0 = bad;
            mstep();
            @(posedge clk);
            #1;
            chk($sformatf("rnd_pc_c%0d", c), dut_val(3, 0), 32'(mpc));
            chk($sformatf("rnd_hi_c%0d", c), dut_val(1, 0), mhi);
            chk($sformatf("rnd_lo_c%0d", c), dut_val(2, 0), mlo);
            for (int r = 0; r < 32; r++)
                chk($sformatf("rnd_r%0d_c%0d", r, c), dut_val(0, r), mreg[r]);
            if (bad != bad0) break;
        end

        // Reset after random activity: everything back to zero.
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pc", dut_val(3, 0), 32'd0);
        chk("rst_hi", dut_val(1, 0), 32'd0);
        chk("rst_lo", dut_val(2, 0), 32'd0);
        for (int r = 0; r < 32; r++)
            chk($sformatf("rst_r%0d", r), dut_val(0, r), 32'd0);
        imem = '0;
        #1 rst = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            @(posedge clk);
            #1 chk($sformatf("rel_pc_%0d", c), dut_val(3, 0), 32'(c));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
